// File: rtl/axi_periph_bridge_pkg.sv
// Shared encodings and helpers for the AXI4-to-peripheral register bridge.
// AXI response/burst codes, FSM state codes and the per-beat address step.
package axi_periph_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWreq,
    StBresp,
    StRreq,
    StRdata
  } state_e;

  // Which direction was granted last; drives round-robin on simultaneous AW/AR.
  typedef enum logic {
    LastRead,
    LastWrite
  } rr_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BurstFixed) ? addr : addr + 32'd4;
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BurstFixed) || (burst == BurstIncr);
  endfunction

endpackage

// File: rtl/axi_periph_bridge.sv
// AXI4 slave turning each beat into one level-strobed peripheral register access.
// One transaction in flight; every peripheral access is bounded by a timeout.
module axi_periph_bridge
  import axi_periph_bridge_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE    = 32'h9000_0000,
  parameter logic [31:0] PERIPH_MASK    = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o,
  output logic [31:0] periph_addr_o,
  output logic [31:0] periph_wdata_o,
  output logic [3:0]  periph_wstrb_o,
  output logic        periph_rd_o,
  output logic        periph_wr_o,
  input  logic        periph_ack_i,
  input  logic        periph_error_i,
  input  logic [31:0] periph_rdata_i
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  rr_e         rr_last_q, rr_last_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        miss_q, miss_d;
  logic        bad_q, bad_d;
  logic        slverr_q, slverr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic        skip_access;
  logic        last_beat;
  logic        req_timeout;
  logic [1:0]  skip_resp;

  assign skip_access = miss_q | bad_q;
  assign last_beat   = (beat_cnt_q == 8'd0);
  assign skip_resp   = miss_q ? RespDecerr : RespSlverr;
  // An ack in the same cycle as expiry takes precedence over the timeout.
  assign req_timeout = (tcnt_q == TimeoutLast) && !periph_ack_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      rr_last_q  <= LastRead;
      addr_q     <= '0;
      id_q       <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      miss_q     <= 1'b0;
      bad_q      <= 1'b0;
      slverr_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      miss_q     <= miss_d;
      bad_q      <= bad_d;
      slverr_q   <= slverr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    addr_d        = addr_q;
    id_d          = id_q;
    burst_d       = burst_q;
    beat_cnt_d    = beat_cnt_q;
    miss_d        = miss_q;
    bad_d         = bad_q;
    slverr_d      = slverr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    tcnt_d        = '0;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    periph_rd_o   = 1'b0;
    periph_wr_o   = 1'b0;

    case (state_q)
      StIdle: begin
        // At most one ready is high when both channels request.
        axi_awready_o = rst_i && !(axi_arvalid_i && (rr_last_q == LastWrite));
        axi_arready_o = rst_i && !(axi_awvalid_i && (rr_last_q == LastRead));
        if (axi_awvalid_i && axi_awready_o) begin
          addr_d     = axi_awaddr_i;
          id_d       = axi_awid_i;
          burst_d    = axi_awburst_i;
          beat_cnt_d = axi_awlen_i;
          miss_d     = (axi_awaddr_i & PERIPH_MASK) != PERIPH_BASE;
          bad_d      = !burst_ok(axi_awburst_i);
          slverr_d   = 1'b0;
          state_d    = StWdata;
        end else if (axi_arvalid_i && axi_arready_o) begin
          addr_d     = axi_araddr_i;
          id_d       = axi_arid_i;
          burst_d    = axi_arburst_i;
          beat_cnt_d = axi_arlen_i;
          miss_d     = (axi_araddr_i & PERIPH_MASK) != PERIPH_BASE;
          bad_d      = !burst_ok(axi_arburst_i);
          state_d    = StRreq;
        end
      end

      StWdata: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) begin
          wdata_d = axi_wdata_i;
          wstrb_d = axi_wstrb_i;
          if (axi_wlast_i != last_beat) slverr_d = 1'b1;
          if (!skip_access) begin
            state_d = StWreq;
          end else if (last_beat) begin
            state_d = StBresp;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end

      StWreq: begin
        periph_wr_o = 1'b1;
        if (periph_ack_i || req_timeout) begin
          if (req_timeout || periph_error_i) slverr_d = 1'b1;
          if (last_beat) begin
            state_d = StBresp;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            addr_d     = next_addr(addr_q, burst_q);
            state_d    = StWdata;
          end
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      StBresp: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) begin
          rr_last_d = LastWrite;
          state_d   = StIdle;
        end
      end

      StRreq: begin
        if (skip_access) begin
          rdata_d = '0;
          rresp_d = skip_resp;
          state_d = StRdata;
        end else begin
          periph_rd_o = 1'b1;
          if (periph_ack_i) begin
            rdata_d = periph_rdata_i;
            rresp_d = periph_error_i ? RespSlverr : RespOkay;
            state_d = StRdata;
          end else if (req_timeout) begin
            rdata_d = '0;
            rresp_d = RespSlverr;
            state_d = StRdata;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
      end

      StRdata: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) begin
          if (last_beat) begin
            rr_last_d = LastRead;
            state_d   = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            addr_d     = next_addr(addr_q, burst_q);
            state_d    = StRreq;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Worst response of the burst: DECERR over SLVERR over OKAY.
  always_comb begin
    if (miss_q) begin
      axi_bresp_o = RespDecerr;
    end else if (bad_q || slverr_q) begin
      axi_bresp_o = RespSlverr;
    end else begin
      axi_bresp_o = RespOkay;
    end
  end

  assign axi_bid_o      = id_q;
  assign axi_rid_o      = id_q;
  assign axi_rdata_o    = rdata_q;
  assign axi_rresp_o    = rresp_q;
  assign axi_rlast_o    = (state_q == StRdata) && last_beat;
  assign periph_addr_o  = addr_q;
  assign periph_wdata_o = wdata_q;
  assign periph_wstrb_o = wstrb_q;

endmodule
